// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: READ, then CONV layers and a POOL for each active group, then FC, WRITE, DONE.
// It drives one-hot bus ownership, single-cycle engine start pulses and a per-state watchdog.
module layer_seq_ctrl #(
  parameter int                       NGROUP     = 4,
  parameter int                       CNT_W      = 4,
  parameter logic [NGROUP*CNT_W-1:0]  LAYER_DEF  = 16'h4444,
  parameter int                       ADDR_W     = 28,
  parameter logic [ADDR_W-1:0]        FLT_BASE   = '0,
  parameter logic [ADDR_W-1:0]        FLT_STRIDE = 'h100,
  parameter int                       TMO_W      = 20,
  parameter logic [TMO_W-1:0]         TMO_MAX    = 20'hFFFFF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            system_end,
  output logic                            err,
  output logic [1:0]                      err_code,
  input  logic                            rdone,
  input  logic                            wdone,
  output logic                            uart_en,
  output logic [2:0]                      uart_wrSel,
  output logic                            uart_link_read,
  output logic                            uart_link_write,
  output logic                            conv_start,
  input  logic                            conv_done,
  output logic [ADDR_W-1:0]               conv_init_addr,
  output logic                            conv_init_addr_en,
  output logic                            pool_start,
  input  logic                            pool_done,
  output logic                            fc_start,
  input  logic                            fc_done,
  output logic [2:0]                      link_sel,
  output logic [$clog2(NGROUP+1)-1:0]     group_idx,
  output logic [CNT_W-1:0]                layer_idx
);

  localparam int GW = $clog2(NGROUP+1);

  function automatic int active_groups();
    int k;
    k = NGROUP;
    for (int g = NGROUP - 1; g >= 0; g--)
      if (LAYER_DEF[g*CNT_W +: CNT_W] == '0) k = g;
    return k;
  endfunction

  localparam int K = active_groups();

  function automatic logic [CNT_W-1:0] group_count(input logic [GW-1:0] g);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NGROUP; i++)
      if (g == GW'(i)) c = LAYER_DEF[i*CNT_W +: CNT_W];
    return c;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CONV, S_POOL, S_FC, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t             st_q, st_d;
  logic [GW-1:0]      grp_q, grp_d;
  logic [CNT_W-1:0]   lay_q, lay_d;
  logic [ADDR_W-1:0]  naddr_q, naddr_d;
  logic [TMO_W-1:0]   wdog_q;
  logic [1:0]         ecode_d;
  logic               reenter, enter, watched, tmo;

  assign watched   = st_q inside {S_READ, S_CONV, S_POOL, S_FC, S_WRITE};
  assign tmo       = watched && (TMO_MAX != '0) && ((wdog_q + TMO_W'(1)) == TMO_MAX);
  assign group_idx = grp_q;
  assign layer_idx = lay_q;

  always_comb begin
    st_d    = st_q;
    grp_d   = grp_q;
    lay_d   = lay_q;
    naddr_d = naddr_q;
    ecode_d = err_code;
    reenter = 1'b0;
    enter   = 1'b0;
    if (watched && abort) begin
      st_d = S_IDLE;
    end else if (tmo) begin
      st_d    = S_ERR;
      ecode_d = (st_q == S_READ) ? 2'b01 : (st_q == S_WRITE) ? 2'b11 : 2'b10;
    end else begin
      case (st_q)
        S_IDLE:  if (start) st_d = S_READ;
        S_READ:  if (rdone) st_d = (K > 0) ? S_CONV : S_FC;
        // a done arriving while our own start pulse is still out belongs to no request
        S_CONV:  if (conv_done && !conv_start) begin
                   if (({1'b0, lay_q} + (CNT_W+1)'(1)) < {1'b0, group_count(grp_q)}) begin
                     lay_d   = lay_q + CNT_W'(1);
                     reenter = 1'b1;
                   end else begin
                     st_d = S_POOL;
                   end
                 end
        S_POOL:  if (pool_done && !pool_start) begin
                   grp_d = grp_q + GW'(1);
                   lay_d = '0;
                   st_d  = ((int'(grp_q) + 1) < K) ? S_CONV : S_FC;
                 end
        S_FC:    if (fc_done && !fc_start) st_d = S_WRITE;
        S_WRITE: if (wdone) st_d = S_DONE;
        S_DONE:  st_d = S_IDLE;
        S_ERR:   if (start || abort) begin
                   st_d    = S_IDLE;
                   ecode_d = '0;
                 end
        default: st_d = S_IDLE;
      endcase
    end
    enter = reenter || (st_d != st_q);
    if (st_d == S_IDLE) begin
      grp_d   = '0;
      lay_d   = '0;
      naddr_d = FLT_BASE;
    end else if (st_d == S_CONV && enter) begin
      naddr_d = naddr_q + FLT_STRIDE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q              <= S_IDLE;
      grp_q             <= '0;
      lay_q             <= '0;
      naddr_q           <= FLT_BASE;
      wdog_q            <= '0;
      busy              <= 1'b0;
      system_end        <= 1'b0;
      err               <= 1'b0;
      err_code          <= '0;
      uart_en           <= 1'b0;
      uart_wrSel        <= '0;
      uart_link_read    <= 1'b0;
      uart_link_write   <= 1'b0;
      conv_start        <= 1'b0;
      conv_init_addr    <= '0;
      conv_init_addr_en <= 1'b0;
      pool_start        <= 1'b0;
      fc_start          <= 1'b0;
      link_sel          <= '0;
    end else begin
      st_q     <= st_d;
      grp_q    <= grp_d;
      lay_q    <= lay_d;
      naddr_q  <= naddr_d;
      if (enter)        wdog_q <= '0;
      else if (watched) wdog_q <= wdog_q + TMO_W'(1);
      // outputs are decoded from the next state so they line up with it
      busy              <= !(st_d inside {S_IDLE, S_ERR});
      system_end        <= (st_d == S_DONE);
      err               <= (st_d == S_ERR);
      err_code          <= ecode_d;
      uart_en           <= (st_d == S_READ) || (st_d == S_WRITE);
      uart_wrSel        <= (st_d == S_WRITE) ? 3'b010 : 3'b000;
      uart_link_read    <= (st_d == S_READ);
      uart_link_write   <= (st_d == S_WRITE);
      conv_start        <= (st_d == S_CONV) && enter;
      conv_init_addr_en <= (st_d == S_CONV) && enter;
      if ((st_d == S_CONV) && enter) conv_init_addr <= naddr_q;
      pool_start        <= (st_d == S_POOL) && enter;
      fc_start          <= (st_d == S_FC) && enter;
      link_sel          <= (st_d == S_CONV) ? 3'b001 :
                           (st_d == S_POOL) ? 3'b010 :
                           (st_d == S_FC)   ? 3'b100 : 3'b000;
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: a randomized responder plays the UART and engines, and the logged
// event stream is compared against the sequence derived from the layer table.
module tb_layer_seq_ctrl;

  localparam logic [15:0] LDEF_A = 16'h0021;
  localparam int STRIDE  = 'h100;
  localparam int EV_CONV = 1, EV_POOL = 2, EV_FC = 3, EV_END = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, rdone = 1'b0, wdone = 1'b0;
  logic conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0;

  logic a_busy, a_system_end, a_err, a_uart_en, a_uart_link_read, a_uart_link_write;
  logic a_conv_start, a_conv_init_addr_en, a_pool_start, a_fc_start;
  logic [1:0] a_err_code;
  logic [2:0] a_uart_wrSel, a_link_sel, a_group_idx;
  logic [3:0] a_layer_idx;
  logic [27:0] a_conv_init_addr;

  logic b_busy, b_system_end, b_err, b_uart_en, b_uart_link_read, b_uart_link_write;
  logic b_conv_start, b_conv_init_addr_en, b_pool_start, b_fc_start;
  logic [1:0] b_err_code;
  logic [2:0] b_uart_wrSel, b_link_sel, b_group_idx;
  logic [3:0] b_layer_idx;
  logic [27:0] b_conv_init_addr;

  layer_seq_ctrl #(.LAYER_DEF(LDEF_A), .FLT_BASE(28'h0), .FLT_STRIDE(28'h100), .TMO_MAX(20'd16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(a_busy),
    .system_end(a_system_end), .err(a_err), .err_code(a_err_code), .rdone(rdone), .wdone(wdone),
    .uart_en(a_uart_en), .uart_wrSel(a_uart_wrSel), .uart_link_read(a_uart_link_read),
    .uart_link_write(a_uart_link_write), .conv_start(a_conv_start), .conv_done(conv_done),
    .conv_init_addr(a_conv_init_addr), .conv_init_addr_en(a_conv_init_addr_en),
    .pool_start(a_pool_start), .pool_done(pool_done), .fc_start(a_fc_start), .fc_done(fc_done),
    .link_sel(a_link_sel), .group_idx(a_group_idx), .layer_idx(a_layer_idx));

  layer_seq_ctrl #(.LAYER_DEF(16'h0000), .TMO_MAX(20'd16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(b_busy),
    .system_end(b_system_end), .err(b_err), .err_code(b_err_code), .rdone(rdone), .wdone(wdone),
    .uart_en(b_uart_en), .uart_wrSel(b_uart_wrSel), .uart_link_read(b_uart_link_read),
    .uart_link_write(b_uart_link_write), .conv_start(b_conv_start), .conv_done(conv_done),
    .conv_init_addr(b_conv_init_addr), .conv_init_addr_en(b_conv_init_addr_en),
    .pool_start(b_pool_start), .pool_done(pool_done), .fc_start(b_fc_start), .fc_done(fc_done),
    .link_sel(b_link_sel), .group_idx(b_group_idx), .layer_idx(b_layer_idx));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct { int kind; int val; int gl; int cyc; } ev_t;
  ev_t evq[$];
  ev_t expq[$];
  bit mon_b = 1'b0;
  int wd_cyc = -1;

  always @(negedge clk) begin
    ev_t e;
    logic cs, ps, fs, se, lw, ae, ue;
    logic [2:0] ls, ws, gi;
    logic [3:0] li;
    logic [27:0] ad;
    if (rst_n) begin
      cs = mon_b ? b_conv_start : a_conv_start;
      ps = mon_b ? b_pool_start : a_pool_start;
      fs = mon_b ? b_fc_start : a_fc_start;
      se = mon_b ? b_system_end : a_system_end;
      lw = mon_b ? b_uart_link_write : a_uart_link_write;
      ae = mon_b ? b_conv_init_addr_en : a_conv_init_addr_en;
      ue = mon_b ? b_uart_en : a_uart_en;
      ls = mon_b ? b_link_sel : a_link_sel;
      ws = mon_b ? b_uart_wrSel : a_uart_wrSel;
      gi = mon_b ? b_group_idx : a_group_idx;
      li = mon_b ? b_layer_idx : a_layer_idx;
      ad = mon_b ? b_conv_init_addr : a_conv_init_addr;
      e.cyc = cyc; e.val = 0; e.gl = 0;
      if (cs) begin
        e.kind = EV_CONV; e.val = int'(ad); e.gl = int'(gi) * 16 + int'(li); evq.push_back(e);
        chk("conv_link", {ls, ae}, 4'b0011);
      end
      if (ps) begin e.kind = EV_POOL; evq.push_back(e); chk("pool_link", ls, 3'b010); end
      if (fs) begin e.kind = EV_FC; evq.push_back(e); chk("fc_link", ls, 3'b100); end
      if (se) begin e.kind = EV_END; evq.push_back(e); end
      if (lw) chk("write_outs", {ue, ws, ls}, 7'b1_010_000);
      if (wdone && lw) wd_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Expected run: every active group contributes its convs (global index n) followed by one pool.
  task automatic build_exp(input logic [15:0] ldef);
    ev_t e;
    int k, n;
    logic [3:0] c;
    expq.delete();
    k = 4;
    for (int g = 3; g >= 0; g--) begin
      c = ldef[g*4 +: 4];
      if (c == 4'd0) k = g;
    end
    n = 0; e.cyc = 0;
    for (int g = 0; g < k; g++) begin
      c = ldef[g*4 +: 4];
      for (int l = 0; l < int'(c); l++) begin
        e.kind = EV_CONV; e.val = n * STRIDE; e.gl = g * 16 + l; expq.push_back(e); n++;
      end
      e.kind = EV_POOL; e.val = 0; e.gl = 0; expq.push_back(e);
    end
    e.kind = EV_FC; expq.push_back(e);
    e.kind = EV_END; expq.push_back(e);
  endtask

  task automatic cmp_events(input string tag, input bit hold);
    chk({tag, "_nev"}, evq.size(), expq.size());
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      chk({tag, "_kind"}, evq[i].kind, expq[i].kind);
      if (expq[i].kind == EV_CONV) begin
        chk({tag, "_addr"}, evq[i].val, expq[i].val);
        chk({tag, "_grp_layer"}, evq[i].gl, expq[i].gl);
      end
      if (hold && i > 0 && evq[i].kind == EV_CONV && evq[i-1].kind == EV_CONV)
        chk({tag, "_hold_gap"}, evq[i].cyc - evq[i-1].cyc, 2);
      if (evq[i].kind == EV_END) chk({tag, "_end_lat"}, evq[i].cyc - wd_cyc, 1);
    end
  endtask

  // Plays UART and engines with random latencies; res: 0 end seen, 1 aborted, 2 reset, 3 budget out.
  task automatic resp(input bit sb, input bit noise, input bit hold, input int abort_at,
                      input bit rst_pool, output int res);
    int cd[5];
    int nconv;
    logic [4:0] own, pls, dn;
    logic endev;
    for (int i = 0; i < 5; i++) cd[i] = -1;
    nconv = 0; res = 3;
    for (int c = 0; c < 300 && res == 3; c++) begin
      tick();
      own = sb ? {b_uart_link_write, b_link_sel == 3'b100, b_link_sel == 3'b010, b_link_sel == 3'b001, b_uart_link_read}
               : {a_uart_link_write, a_link_sel == 3'b100, a_link_sel == 3'b010, a_link_sel == 3'b001, a_uart_link_read};
      pls = sb ? {1'b0, b_fc_start, b_pool_start, b_conv_start, 1'b0}
               : {1'b0, a_fc_start, a_pool_start, a_conv_start, 1'b0};
      endev = sb ? b_system_end : a_system_end;
      if (pls[1]) nconv++;
      if (endev) begin
        res = 0;
      end else if (pls[1] && nconv == abort_at) begin
        {wdone, fc_done, pool_done, conv_done, rdone} = '0;
        start = 1'b0; abort = 1'b1; tick(); abort = 1'b0; res = 1;
      end else if (rst_pool && pls[2]) begin
        start = 1'b0; rst_n = 1'b0; #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_link_sel", a_link_sel, 0);
        chk("rst_pool_start", a_pool_start, 0);
        chk("rst_uart_idx", {a_uart_en, a_group_idx, a_layer_idx}, 0);
        res = 2;
      end else begin
        dn = '0;
        for (int i = 0; i < 5; i++) begin
          if (cd[i] > 0) begin
            cd[i]--;
            if (cd[i] == 0) begin dn[i] = 1'b1; cd[i] = -1; end
          end else if ((i == 0 || i == 4) ? own[i] : pls[i]) begin
            cd[i] = $urandom_range(1, 5);
          end
          if (noise && !own[i] && $urandom_range(0, 3) == 0) dn[i] = 1'b1;
          if (noise && pls[i] && $urandom_range(0, 1) == 1) dn[i] = 1'b1;
        end
        if (hold) dn[1] = 1'b1;
        start = noise && ($urandom_range(0, 7) == 0);
        {wdone, fc_done, pool_done, conv_done, rdone} = dn;
      end
    end
    {wdone, fc_done, pool_done, conv_done, rdone} = '0;
    start = 1'b0;
  endtask

  task automatic run_full(input bit sb, input bit noise, input bit hold, input string tag);
    int res;
    mon_b = sb; evq.delete(); wd_cyc = -1;
    build_exp(sb ? 16'h0000 : LDEF_A);
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, "_busy"}, sb ? b_busy : a_busy, 1);
    chk({tag, "_read_outs"}, sb ? {b_uart_en, b_uart_link_read, b_uart_wrSel, b_link_sel}
                                : {a_uart_en, a_uart_link_read, a_uart_wrSel, a_link_sel}, 8'b11_000_000);
    resp(sb, noise, hold, 0, 1'b0, res);
    chk({tag, "_outcome"}, res, 0);
    tick();
    cmp_events(tag, hold);
    chk({tag, "_idle"}, sb ? {b_busy, b_system_end} : {a_busy, a_system_end}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n, res, nend, nconv;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy_end_err", {a_busy, a_system_end, a_err, a_err_code}, 0);
    chk("rst_uart", {a_uart_en, a_uart_wrSel, a_uart_link_read, a_uart_link_write}, 0);
    chk("rst_pulses", {a_conv_start, a_conv_init_addr_en, a_pool_start, a_fc_start}, 0);
    chk("rst_addr", a_conv_init_addr, 0);
    chk("rst_link_idx", {a_link_sel, a_group_idx, a_layer_idx}, 0);

    run_full(1'b0, 1'b0, 1'b0, "basic");
    for (int i = 0; i < 6; i++) run_full(1'b0, 1'($urandom_range(0, 1)), 1'(i % 2), "rand");

    do_reset();
    run_full(1'b1, 1'b0, 1'b0, "no_layers");
    do_reset();
    mon_b = 1'b0;

    // watchdog while waiting on conv_done
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!a_uart_link_read && n < 20) begin tick(); n++; end
    rdone = 1'b1; tick(); rdone = 1'b0;
    chk("tmo_conv_entry", a_conv_start, 1);
    n = 0;
    while (!a_err && n < 40) begin tick(); n++; end
    chk("tmo_conv_cycles", n, 16);
    chk("tmo_conv_code", {a_err, a_err_code}, 3'b110);
    chk("tmo_conv_quiet", {a_busy, a_link_sel, a_uart_en, a_conv_start}, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("tmo_clear", {a_err, a_err_code, a_busy}, 0);
    tick();
    chk("tmo_stay_idle", a_busy, 0);

    // watchdog while waiting on rdone, cleared by abort
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!a_err && n < 40) begin tick(); n++; end
    chk("tmo_read_cycles", n, 16);
    chk("tmo_read_code", {a_err, a_err_code}, 3'b101);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("tmo_read_abort_clear", {a_err, a_err_code, a_busy}, 0);

    // abort during the second conv
    evq.delete();
    start = 1'b1; tick(); start = 1'b0;
    resp(1'b0, 1'b0, 1'b0, 2, 1'b0, res);
    chk("abort_outcome", res, 1);
    chk("abort_idle", {a_busy, a_link_sel, a_conv_start, a_err, a_system_end}, 0);
    repeat (20) tick();
    nend = 0; nconv = 0;
    foreach (evq[i]) begin
      if (evq[i].kind == EV_END) nend++;
      if (evq[i].kind == EV_CONV) nconv++;
    end
    chk("abort_no_end", nend, 0);
    chk("abort_nconv", nconv, 2);
    run_full(1'b0, 1'b1, 1'b0, "after_abort");

    // reset asserted in POOL
    evq.delete();
    start = 1'b1; tick(); start = 1'b0;
    resp(1'b0, 1'b0, 1'b0, 0, 1'b1, res);
    chk("rst_pool_outcome", res, 2);
    tick();
    rst_n = 1'b1;
    tick();
    run_full(1'b0, 1'b0, 1'b1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 SHALL have parameter NGROUP, 4, maximum number of layer groups (1..8).
REQ-002 SHALL have parameter CNT_W, 4, width of a per-group conv count.
REQ-003 SHALL have parameter LAYER_DEF, 16'h4444 (NGROUP*CNT_W bits), conv count of group g in bits [g*CNT_W +: CNT_W].
REQ-004 SHALL have parameter ADDR_W, 28, filter address width.
REQ-005 SHALL have parameter FLT_BASE, 0, filter address of first conv.
REQ-006 SHALL have parameter FLT_STRIDE, 'h100, address step per conv.
REQ-007 SHALL have parameter TMO_W, 20, watchdog width; TMO_MAX, 20'hFFFFF, timeout limit (0 disables).
REQ-008 SHALL have ports clk in 1 clock; rst_n in 1, asynchronous, active-low reset.
REQ-009 SHALL have ports start in 1 run request; abort in 1 cancel; busy out 1 not IDLE/ERR; system_end out 1 run-complete pulse.
REQ-010 SHALL have ports err out 1 sticky error; err_code out 2 (01 read, 10 engine, 11 write timeout).
REQ-011 SHALL have ports rdone in 1; wdone in 1; uart_en out 1; uart_wrSel out 3; uart_link_read out 1; uart_link_write out 1.
REQ-012 SHALL have ports conv_start out 1 pulse; conv_done in 1; conv_init_addr out ADDR_W; conv_init_addr_en out 1 pulse.
REQ-013 SHALL have ports pool_start out 1 pulse; pool_done in 1; fc_start out 1 pulse; fc_done in 1.
REQ-014 SHALL have ports link_sel out 3 one-hot {fc,pool,conv} bus ownership; group_idx out clog2(NGROUP+1); layer_idx out CNT_W.

Function
REQ-015 SHALL implement states IDLE, READ, CONV, POOL, FC, WRITE, DONE, ERR, registered, one transition per clock max.
REQ-016 Active groups SHALL be groups 0..k-1 where group k is the first with count 0 (or k=NGROUP).
REQ-017 IDLE: start -> READ; otherwise hold.
REQ-018 READ: uart_en=1, uart_wrSel=000, uart_link_read=1; rdone -> CONV (group 0, layer 0) if k>0, else FC.
REQ-019 On every CONV entry: conv_start and conv_init_addr_en high exactly one cycle, conv_init_addr = FLT_BASE + n*FLT_STRIDE (n = global conv index from 0, truncated to ADDR_W), link_sel=001.
REQ-020 CONV on conv_done: layer_idx+1 < count(group_idx) -> layer_idx+1, re-enter CONV (new pulse); else -> POOL.
REQ-021 POOL entry: pool_start one-cycle pulse, link_sel=010; pool_done -> group_idx+1, layer_idx=0; next group active -> CONV, else -> FC.
REQ-022 FC entry: fc_start one-cycle pulse, link_sel=100; fc_done -> WRITE.
REQ-023 WRITE: uart_en=1, uart_wrSel=010, uart_link_write=1, link_sel=000; wdone -> DONE.
REQ-024 DONE: system_end=1 for one cycle, -> IDLE; counters cleared.
REQ-025 Done inputs SHALL be ignored in the cycle the matching start pulse is asserted and in states that do not own them.
REQ-026 Watchdog SHALL clear on every state entry and count each cycle in READ/CONV/POOL/FC/WRITE; reaching TMO_MAX (nonzero) -> ERR with err_code per REQ-010, err=1.
REQ-027 ERR: all enables/links/pulses 0; start or abort -> IDLE, clearing err and err_code.
REQ-028 Priority SHALL be abort > timeout > done; abort in any busy state -> IDLE next cycle, no system_end, no err.
REQ-029 start SHALL be ignored when busy=1.
REQ-030 Outputs SHALL be registered; no combinational path input->output.

Reset
REQ-031 rst_n low SHALL force IDLE asynchronously, all outputs 0, counters/watchdog 0, including mid-operation.
REQ-032 First start after reset release SHALL behave as REQ-017.

Verification
REQ-033 LAYER_DEF=16'h0021, FLT_BASE=0, FLT_STRIDE='h100: start, rdone, then done on each start -> conv addrs 0, 'h100, 'h200; pool_start after conv 1 and conv 3; one fc_start; uart_wrSel=010 in WRITE; system_end one cycle after wdone.
REQ-034 LAYER_DEF=0: start, rdone -> FC directly, zero conv/pool pulses.
REQ-035 TMO_MAX=16, conv_done never asserted -> ERR 16 cycles after CONV entry, err=1, err_code=10; start -> IDLE, err=0.
REQ-036 Abort during 2nd conv -> IDLE next cycle, busy=0, system_end never asserted; new start restarts at address 0.
REQ-037 conv_done held high continuously -> exactly one layer advance per conv_start, none in pulse cycle.
REQ-038 rst_n asserted during POOL -> all outputs 0 immediately; after release, start runs full sequence from group 0.
